// File: rtl/alu_pkg.sv
// Shared ALU control codes, operation encodings, buffer entry layout and occupancy states
// for the execute stage and its combinational core.
package alu_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned TAG_W_DEF = 5;

    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_INVALID = 4'b1111;

    typedef enum logic [3:0] {
        OpAnd = ALU_AND,
        OpOr  = ALU_OR,
        OpAdd = ALU_ADD,
        OpSub = ALU_SUB,
        OpSlt = ALU_SLT,
        OpInv = ALU_INVALID
    } alu_op_e;

    // Entry layout is fixed at the default widths; the stage is built with matching parameters.
    typedef struct packed {
        logic [XLEN_DEF-1:0]  result;
        logic                 zero;
        logic                 branch_taken;
        logic                 illegal;
        logic [TAG_W_DEF-1:0] rd;
    } ex_entry_t;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } occ_state_e;

endpackage

// File: rtl/alu_ex_stage_if.sv
// Upstream/downstream handshake and payload bundle of the execute stage.
// The stage connects through the slave modport, the surrounding pipeline through master.
interface alu_ex_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_alu_control;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic             in_is_branch;
    logic [TAG_W-1:0] in_rd;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic             out_zero;
    logic             out_branch_taken;
    logic             out_illegal;
    logic [TAG_W-1:0] out_rd;

    modport slave (
        input  flush, in_valid, in_alu_control, in_a, in_b, in_is_branch, in_rd, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_branch_taken, out_illegal, out_rd
    );

    modport master (
        output flush, in_valid, in_alu_control, in_a, in_b, in_is_branch, in_rd, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_branch_taken, out_illegal, out_rd
    );

endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU: {control, a, b} -> {result, illegal}.
// Signed set-less-than (code 0111) exists only when ALU_EX_SLT_EN is defined.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [3:0]      control,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (control)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
`ifdef ALU_EX_SLT_EN
            ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
`endif
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ex_stage.sv
// Registered execute stage: ALU result computed at the input, held in a 2-entry FIFO buffer.
// Optional signed SLT via ALU_EX_SLT_EN (handled in alu_core).
module alu_ex_stage
    import alu_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned TAG_W = TAG_W_DEF
) (
    input logic           clk,
    input logic           rst,
    alu_ex_stage_if.slave bus
);

    occ_state_e      state_q, state_d;
    ex_entry_t       head_q, head_d;
    ex_entry_t       tail_q, tail_d;
    ex_entry_t       new_entry;
    logic            in_ready_q;
    logic            push, pop;
    logic [XLEN-1:0] core_result;
    logic            core_illegal;

    alu_core #(
        .XLEN (XLEN)
    ) u_core (
        .control (bus.in_alu_control),
        .a       (bus.in_a),
        .b       (bus.in_b),
        .result  (core_result),
        .illegal (core_illegal)
    );

    always_comb begin
        new_entry              = '0;
        new_entry.result       = core_result;
        new_entry.zero         = (core_result == '0);
        // Illegal beats read as zero but must never redirect the front end.
        new_entry.branch_taken = bus.in_is_branch & (core_result == '0) & ~core_illegal;
        new_entry.illegal      = core_illegal;
        new_entry.rd           = bus.in_rd;
    end

    assign push = bus.in_valid & in_ready_q;
    assign pop  = (state_q != StEmpty) & bus.out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            StEmpty: begin
                if (push) begin
                    state_d = StOne;
                    head_d  = new_entry;
                end
            end
            StOne: begin
                if (push && !pop) begin
                    state_d = StTwo;
                    tail_d  = new_entry;
                end else if (!push && pop) begin
                    state_d = StEmpty;
                end else if (push && pop) begin
                    head_d = new_entry;
                end
            end
            StTwo: begin
                if (pop) begin
                    state_d = StOne;
                    head_d  = tail_q;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (bus.flush) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StEmpty;
            head_q     <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= (state_d != StTwo);
        end
    end

    assign bus.in_ready         = in_ready_q;
    assign bus.out_valid        = (state_q != StEmpty);
    assign bus.out_result       = head_q.result;
    assign bus.out_zero         = head_q.zero;
    assign bus.out_branch_taken = head_q.branch_taken;
    assign bus.out_illegal      = head_q.illegal;
    assign bus.out_rd           = head_q.rd;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed self-checking bench for alu_ex_stage with hand-computed expected values.
// SLT expectations follow ALU_EX_SLT_EN.
module tb_alu_ex_stage;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    alu_ex_stage_if #(.XLEN(32), .TAG_W(5)) bus ();

    alu_ex_stage #(
        .XLEN  (32),
        .TAG_W (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] res, input logic z,
                              input logic bt, input logic ill, input logic [4:0] rd);
        check({tag, ".valid"}, 64'(bus.out_valid), 64'(1'b1));
        check({tag, ".result"}, 64'(bus.out_result), 64'(res));
        check({tag, ".zero"}, 64'(bus.out_zero), 64'(z));
        check({tag, ".taken"}, 64'(bus.out_branch_taken), 64'(bt));
        check({tag, ".illegal"}, 64'(bus.out_illegal), 64'(ill));
        check({tag, ".rd"}, 64'(bus.out_rd), 64'(rd));
    endtask

    task automatic set_beat(input logic v, input logic [3:0] ctl, input logic [31:0] a,
                            input logic [31:0] b, input logic br, input logic [4:0] rd);
        bus.in_valid       = v;
        bus.in_alu_control = ctl;
        bus.in_a           = a;
        bus.in_b           = b;
        bus.in_is_branch   = br;
        bus.in_rd          = rd;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] slt_res;
        logic        slt_ill;
`ifdef ALU_EX_SLT_EN
        slt_res = 32'd1;
        slt_ill = 1'b0;
`else
        slt_res = 32'd0;
        slt_ill = 1'b1;
`endif
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        set_beat(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 5'd0);

        // Reset state
        #12;
        check("rst.valid", 64'(bus.out_valid), 64'(1'b0));
        check("rst.in_ready", 64'(bus.in_ready), 64'(1'b0));
        check("rst.result", 64'(bus.out_result), 64'h0);
        check("rst.rd", 64'(bus.out_rd), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst.in_ready", 64'(bus.in_ready), 64'(1'b1));

        // ADD wrap and SUB zero with branch, one-cycle latency
        @(negedge clk);
        bus.out_ready = 1'b1;
        set_beat(1'b1, 4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b1, 5'd3);
        tick();
        check_head("add_wrap", 32'h8000_0000, 1'b0, 1'b0, 1'b0, 5'd3);
        @(negedge clk);
        set_beat(1'b1, 4'b0110, 32'd5, 32'd5, 1'b1, 5'd4);
        tick();
        check_head("sub_zero", 32'h0, 1'b1, 1'b1, 1'b0, 5'd4);

        // AND / OR back to back
        @(negedge clk);
        set_beat(1'b1, 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 5'd5);
        tick();
        check_head("and", 32'h00F0_00F0, 1'b0, 1'b0, 1'b0, 5'd5);
        @(negedge clk);
        set_beat(1'b1, 4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 5'd6);
        tick();
        check_head("or", 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0, 5'd6);
        check("or.in_ready", 64'(bus.in_ready), 64'(1'b1));
        @(negedge clk);
        bus.in_valid = 1'b0;
        tick();
        check("drain.valid", 64'(bus.out_valid), 64'(1'b0));

        // Illegal code with branch, then code 0111
        @(negedge clk);
        set_beat(1'b1, 4'b1111, 32'h1234, 32'h5678, 1'b1, 5'd7);
        tick();
        check_head("illegal", 32'h0, 1'b1, 1'b0, 1'b1, 5'd7);
        @(negedge clk);
        set_beat(1'b1, 4'b0111, 32'hFFFF_FFFF, 32'h1, 1'b0, 5'd8);
        tick();
        check_head("slt", slt_res, (slt_res == 32'h0), 1'b0, slt_ill, 5'd8);
        @(negedge clk);
        bus.in_valid = 1'b0;
        tick();

        // Backpressure: third beat refused, head stable, in-order drain
        @(negedge clk);
        bus.out_ready = 1'b0;
        set_beat(1'b1, 4'b0010, 32'd10, 32'd1, 1'b0, 5'd1);
        tick();
        check_head("bp.a", 32'd11, 1'b0, 1'b0, 1'b0, 5'd1);
        check("bp.a.in_ready", 64'(bus.in_ready), 64'(1'b1));
        @(negedge clk);
        set_beat(1'b1, 4'b0110, 32'd10, 32'd3, 1'b0, 5'd2);
        tick();
        check("bp.full.in_ready", 64'(bus.in_ready), 64'(1'b0));
        check_head("bp.hold1", 32'd11, 1'b0, 1'b0, 1'b0, 5'd1);
        @(negedge clk);
        set_beat(1'b1, 4'b0001, 32'd1, 32'd2, 1'b0, 5'd5);
        tick();
        check("bp.refused.in_ready", 64'(bus.in_ready), 64'(1'b0));
        check_head("bp.hold2", 32'd11, 1'b0, 1'b0, 1'b0, 5'd1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        tick();
        check_head("bp.b", 32'd7, 1'b0, 1'b0, 1'b0, 5'd2);
        check("bp.pop.in_ready", 64'(bus.in_ready), 64'(1'b1));
        tick();
        check_head("bp.c", 32'd3, 1'b0, 1'b0, 1'b0, 5'd5);
        @(negedge clk);
        bus.in_valid = 1'b0;
        tick();
        check("bp.empty", 64'(bus.out_valid), 64'(1'b0));

        // Flush with two entries and a concurrent beat
        @(negedge clk);
        bus.out_ready = 1'b0;
        set_beat(1'b1, 4'b0000, 32'hFF, 32'h0F, 1'b0, 5'd9);
        tick();
        @(negedge clk);
        set_beat(1'b1, 4'b0010, 32'd1, 32'd1, 1'b0, 5'd10);
        tick();
        @(negedge clk);
        bus.flush = 1'b1;
        set_beat(1'b1, 4'b0110, 32'd9, 32'd2, 1'b0, 5'd11);
        tick();
        check("flush2.valid", 64'(bus.out_valid), 64'(1'b0));
        check("flush2.in_ready", 64'(bus.in_ready), 64'(1'b1));
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("flush2.after", 64'(bus.out_valid), 64'(1'b0));

        // Flush in ONE with a beat that does handshake
        @(negedge clk);
        set_beat(1'b1, 4'b0010, 32'd2, 32'd2, 1'b0, 5'd12);
        tick();
        @(negedge clk);
        bus.flush = 1'b1;
        set_beat(1'b1, 4'b0010, 32'd3, 32'd3, 1'b0, 5'd13);
        tick();
        check("flush1.valid", 64'(bus.out_valid), 64'(1'b0));
        check("flush1.in_ready", 64'(bus.in_ready), 64'(1'b1));
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("flush1.after", 64'(bus.out_valid), 64'(1'b0));

        // Asynchronous reset mid-stream
        @(negedge clk);
        set_beat(1'b1, 4'b0110, 32'd3, 32'd3, 1'b1, 5'd7);
        tick();
        check_head("pre_rst", 32'h0, 1'b1, 1'b1, 1'b0, 5'd7);
        @(negedge clk);
        set_beat(1'b1, 4'b1111, 32'd2, 32'd3, 1'b0, 5'd14);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst.valid", 64'(bus.out_valid), 64'(1'b0));
        check("arst.in_ready", 64'(bus.in_ready), 64'(1'b0));
        check("arst.result", 64'(bus.out_result), 64'h0);
        check("arst.zero", 64'(bus.out_zero), 64'(1'b0));
        check("arst.taken", 64'(bus.out_branch_taken), 64'(1'b0));
        check("arst.illegal", 64'(bus.out_illegal), 64'(1'b0));
        check("arst.rd", 64'(bus.out_rd), 64'h0);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("arst.release.in_ready", 64'(bus.in_ready), 64'(1'b1));
        check("arst.release.valid", 64'(bus.out_valid), 64'(1'b0));
        @(negedge clk);
        bus.out_ready = 1'b1;
        set_beat(1'b1, 4'b0010, 32'd20, 32'd22, 1'b0, 5'd15);
        tick();
        check_head("arst.first", 32'd42, 1'b0, 1'b0, 1'b0, 5'd15);
        @(negedge clk);
        bus.in_valid = 1'b0;
        tick();
        check("arst.drain", 64'(bus.out_valid), 64'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
